dma_io_device: RTL

- Peripheral-side endpoint of the 8237A DMA handshake: the device that raises DREQ, waits for DACK and serves IOR/IOW strobes.
- Buffers data in a small FIFO between a local streaming interface and the DMA data bus.
- Used as the channel-side responder in the DMA subsystem and as the bus model for controller-level benches.

---
 rtl/dma_io_device.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dma_io_device.sv
// Peripheral-side 8237A DMA endpoint: raises DREQ, serves IOR/IOW strobes under
// DACK, and buffers data in a small FIFO between the bus and a local stream.
module dma_io_device #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int DREQ_ACTIVE_HIGH = 1,
  parameter int DACK_ACTIVE_HIGH = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  enable,
  input  logic                  dir,
  output logic                  DREQ,
  input  logic                  DACK,
  input  logic                  IOR_N,
  input  logic                  IOW_N,
  input  logic                  EOP_N,
  input  logic [DATA_WIDTH-1:0] db_in,
  output logic [DATA_WIDTH-1:0] db_out,
  output logic                  db_oe,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  pop_ready,
  output logic [15:0]           xfer_count,
  output logic                  done,
  output logic                  err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_END} state_t;

  state_t                  state;
  logic                    dir_q, dreq_r, eop_seen;
  logic                    ior_q, iow_q, clash;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr, count, count_nxt;

  logic full, empty, eff_dir, dack_act, ack_live, both_low;
  logic ior_rise, iow_rise, bus_pop, bus_push, bus_xfer, bus_err;
  logic local_push, local_pop, do_push, do_pop, ready, ready_nxt;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign eff_dir  = (state == S_IDLE) ? dir : dir_q;
  assign dack_act = (DACK == 1'(DACK_ACTIVE_HIGH));
  assign ack_live = (state == S_ACK) && dack_act;
  assign both_low = !IOR_N && !IOW_N;

  // A strobe that overlapped the other strobe never counts, even if it is
  // the last one to release.
  assign ior_rise = !ior_q && IOR_N && IOW_N && !clash;
  assign iow_rise = !iow_q && IOW_N && IOR_N && !clash;

  assign bus_pop  = ack_live && !dir_q && ior_rise && !empty;
  assign bus_push = ack_live &&  dir_q && iow_rise && !full;
  assign bus_xfer = bus_pop || bus_push;
  assign bus_err  = ack_live && (both_low ||
                    (!dir_q && (!IOW_N || (ior_rise && empty))) ||
                    ( dir_q && (!IOR_N || (iow_rise && full))));

  assign push_ready = !full && !eff_dir;
  assign pop_valid  = !empty && eff_dir;
  assign pop_data   = mem[rd_ptr[AW-1:0]];
  assign local_push = push_valid && push_ready;
  assign local_pop  = pop_valid && pop_ready;
  assign do_push    = local_push || bus_push;
  assign do_pop     = local_pop || bus_pop;
  assign count_nxt  = count + (do_push ? ONE : '0) - (do_pop ? ONE : '0);

  assign ready     = eff_dir ? !full : !empty;
  assign ready_nxt = dir_q ? (count_nxt != FULL_CNT) : (count_nxt != '0);

  assign db_oe  = ack_live && !dir_q && !IOR_N && IOW_N;
  assign db_out = db_oe ? mem[rd_ptr[AW-1:0]] : '0;
  assign DREQ   = (DREQ_ACTIVE_HIGH != 0) ? dreq_r : !dreq_r;

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= bus_push ? db_in : push_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      dir_q      <= 1'b0;
      dreq_r     <= 1'b0;
      eop_seen   <= 1'b0;
      ior_q      <= 1'b1;
      iow_q      <= 1'b1;
      clash      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      xfer_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ior_q <= IOR_N;
      iow_q <= IOW_N;
      if (both_low)           clash <= 1'b1;
      else if (IOR_N && IOW_N) clash <= 1'b0;
      done <= 1'b0;

      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
      count <= count_nxt;

      if (bus_err) err <= 1'b1;
      if (bus_xfer && xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;

      case (state)
        S_IDLE: if (enable && ready) begin
          dir_q      <= dir;
          xfer_count <= '0;
          eop_seen   <= 1'b0;
          dreq_r     <= 1'b1;
          state      <= S_REQ;
        end
        S_REQ: if (dack_act) state <= S_ACK;
        S_ACK: begin
          if (!dack_act) begin
            dreq_r <= 1'b0;
            done   <= 1'b1;
            state  <= S_END;
          end else if (!EOP_N) begin
            eop_seen <= 1'b1;
            dreq_r   <= 1'b0;
          end else begin
            // Demand mode: hold the request only while another transfer fits.
            dreq_r <= !eop_seen && ready_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
